// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a start/stop handshake and a small hardware loop stack.
// Consumes one opcode per unstalled cycle in RUN; every output comes straight from a register.
module pc_sequencer #(
    parameter int                    OPCODE_LEN = 4,
    parameter int                    PC_WIDTH   = 12,
    parameter int                    CNT_WIDTH  = 8,
    parameter int                    LOOP_DEPTH = 4,
    parameter logic [OPCODE_LEN-1:0] OP_STOP    = 4'h8,
    parameter logic [OPCODE_LEN-1:0] OP_JUMP    = 4'h9,
    parameter logic [OPCODE_LEN-1:0] OP_LOOP    = 4'hA,
    parameter logic [OPCODE_LEN-1:0] OP_ENDL    = 4'hB
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  valid,
    input  logic [PC_WIDTH-1:0]   start_addr,
    input  logic                  stall,
    input  logic [OPCODE_LEN-1:0] instruction,
    input  logic [PC_WIDTH-1:0]   operand,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  busy,
    output logic                  done,
    output logic                  loop_err
);

    localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_loopErr;
    logic [SP_W-1:0]       r_sp;
    logic [PC_WIDTH-1:0]   r_loopStart [LOOP_DEPTH];
    logic [CNT_WIDTH-1:0]  r_loopCount [LOOP_DEPTH];

    logic [PC_WIDTH-1:0]   w_pcNext;
    logic [PC_WIDTH-1:0]   w_pcInc;
    logic                  w_busyNext;
    logic                  w_doneNext;
    logic                  w_errNext;
    logic [SP_W-1:0]       w_spNext;
    logic                  w_push;
    logic                  w_dec;
    logic                  w_full;
    logic                  w_empty;
    logic [IDX_W-1:0]      w_topIdx;
    logic [IDX_W-1:0]      w_pushIdx;
    logic [CNT_WIDTH-1:0]  w_pushCount;

    assign w_pcInc     = r_pc + PC_WIDTH'(1);
    assign w_full      = (r_sp == SP_W'(LOOP_DEPTH));
    assign w_empty     = (r_sp == '0);
    assign w_topIdx    = IDX_W'(r_sp - SP_W'(1));
    assign w_pushIdx   = IDX_W'(r_sp);
    // A zero iteration count still runs the body once, so it is stored as 1.
    assign w_pushCount = (operand[CNT_WIDTH-1:0] == '0) ? CNT_WIDTH'(1) : operand[CNT_WIDTH-1:0];

    // State and datapath registers; the stack is emptied by clearing only its pointer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_loopErr <= 1'b0;
            r_sp      <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_pc      <= w_pcNext;
            r_busy    <= w_busyNext;
            r_done    <= w_doneNext;
            r_loopErr <= w_errNext;
            r_sp      <= w_spNext;
            if (w_push) begin
                r_loopStart[w_pushIdx] <= w_pcInc;
                r_loopCount[w_pushIdx] <= w_pushCount;
            end
            if (w_dec) begin
                r_loopCount[w_topIdx] <= r_loopCount[w_topIdx] - CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (valid) w_stateNext = RUN;
            RUN:     if (!stall && instruction == OP_STOP) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Next values for the registered outputs and the loop stack; stall freezes all of RUN.
    always_comb begin
        w_pcNext   = r_pc;
        w_busyNext = r_busy;
        w_doneNext = 1'b0;
        w_errNext  = r_loopErr;
        w_spNext   = r_sp;
        w_push     = 1'b0;
        w_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_pcNext   = start_addr;
                    w_busyNext = 1'b1;
                    w_errNext  = 1'b0;
                    w_spNext   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    w_pcNext = w_pcInc;
                    case (instruction)
                        OP_STOP: begin
                            w_pcNext   = '0;
                            w_busyNext = 1'b0;
                            w_doneNext = 1'b1;
                            w_spNext   = '0;
                        end
                        OP_JUMP: w_pcNext = operand;
                        OP_LOOP: begin
                            if (w_full) begin
                                w_errNext = 1'b1;
                            end else begin
                                w_push   = 1'b1;
                                w_spNext = r_sp + SP_W'(1);
                            end
                        end
                        OP_ENDL: begin
                            if (w_empty) begin
                                w_errNext = 1'b1;
                            end else if (r_loopCount[w_topIdx] > CNT_WIDTH'(1)) begin
                                w_dec    = 1'b1;
                                w_pcNext = r_loopStart[w_topIdx];
                            end else begin
                                w_spNext = r_sp - SP_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign pc       = r_pc;
    assign busy     = r_busy;
    assign done     = r_done;
    assign loop_err = r_loopErr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of directed vectors followed by random
// stimulus compared against a queue-based reference model.
module tb_pc_sequencer;

    localparam int STOP  = 8;
    localparam int JUMP  = 9;
    localparam int LOOP  = 10;
    localparam int ENDL  = 11;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic [11:0] start_addr;
    logic        stall;
    logic [3:0]  instruction;
    logic [11:0] operand;
    logic [11:0] pc;
    logic        busy;
    logic        done;
    logic        loop_err;

    int nChecks = 0;
    int nPass   = 0;

    pc_sequencer dut (
        .clk(clk), .rstn(rstn), .valid(valid), .start_addr(start_addr),
        .stall(stall), .instruction(instruction), .operand(operand),
        .pc(pc), .busy(busy), .done(done), .loop_err(loop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        valid;
        logic [11:0] startAddr;
        logic        stall;
        logic [3:0]  instr;
        logic [11:0] operand;
        logic [11:0] expPc;
        logic        expBusy;
        logic        expDone;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: program state held as plain integers and a pair of queues for the stack.
    int mPc;
    bit mBusy;
    bit mDone;
    bit mErr;
    int qStart[$];
    int qCount[$];

    function automatic void modelStep(input bit r, input bit v, input int sa, input bit st,
                                      input int ins, input int op);
        if (!r) begin
            mPc = 0; mBusy = 0; mDone = 0; mErr = 0;
            qStart.delete(); qCount.delete();
        end else if (!mBusy) begin
            mDone = 0;
            if (v) begin
                mPc = sa; mBusy = 1; mErr = 0;
                qStart.delete(); qCount.delete();
            end
        end else begin
            mDone = 0;
            if (!st) begin
                if (ins == STOP) begin
                    mPc = 0; mBusy = 0; mDone = 1;
                    qStart.delete(); qCount.delete();
                end else if (ins == JUMP) begin
                    mPc = op;
                end else if (ins == LOOP) begin
                    if (qStart.size() == DEPTH) begin
                        mErr = 1;
                    end else begin
                        qStart.push_back((mPc + 1) % 4096);
                        qCount.push_back((op % 256 == 0) ? 1 : op % 256);
                    end
                    mPc = (mPc + 1) % 4096;
                end else if (ins == ENDL) begin
                    if (qStart.size() == 0) begin
                        mErr = 1;
                        mPc = (mPc + 1) % 4096;
                    end else if (qCount[qCount.size()-1] > 1) begin
                        qCount[qCount.size()-1] = qCount[qCount.size()-1] - 1;
                        mPc = qStart[qStart.size()-1];
                    end else begin
                        void'(qStart.pop_back());
                        void'(qCount.pop_back());
                        mPc = (mPc + 1) % 4096;
                    end
                end else begin
                    mPc = (mPc + 1) % 4096;
                end
            end
        end
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input int sa, input bit st,
                                 input int ins, input int op);
        rstn        = r;
        valid       = v;
        start_addr  = 12'(sa);
        stall       = st;
        instruction = 4'(ins);
        operand     = 12'(op);
        modelStep(r, v, sa, st, ins, op);
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input string field, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
    endtask

    task automatic checkOutput(input string name, input int ePc, input bit eBusy,
                               input bit eDone, input bit eErr);
        checkField(name, "pc",       int'(pc),       ePc);
        checkField(name, "busy",     int'(busy),     int'(eBusy));
        checkField(name, "done",     int'(done),     int'(eDone));
        checkField(name, "loop_err", int'(loop_err), int'(eErr));
    endtask

    function automatic void addVec(input bit r, input bit v, input int sa, input bit st,
                                   input int ins, input int op, input int ePc,
                                   input bit eBusy, input bit eDone, input bit eErr);
        vec_t x;
        x.rstn = r; x.valid = v; x.startAddr = 12'(sa); x.stall = st;
        x.instr = 4'(ins); x.operand = 12'(op); x.expPc = 12'(ePc);
        x.expBusy = eBusy; x.expDone = eDone; x.expErr = eErr;
        vecs.push_back(x);
    endfunction

    initial begin
        rstn = 1'b0; valid = 1'b0; start_addr = '0; stall = 1'b0; instruction = '0; operand = '0;

        //      rstn valid start  stall instr op     pc     busy done err
        addVec(0, 0, 0,     0, 0,    0,     12'h000, 0, 0, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h000, 0, 0, 0);
        addVec(1, 1, 12'h010, 0, 0,  0,     12'h010, 1, 0, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h011, 1, 0, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h012, 1, 0, 0);
        addVec(1, 0, 0,     0, STOP, 0,     12'h000, 0, 1, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h000, 0, 0, 0);
        // Jump, stall that overrides STOP, valid ignored while running, restart right after done.
        addVec(1, 1, 12'h005, 0, 0,  0,     12'h005, 1, 0, 0);
        addVec(1, 0, 0,     0, JUMP, 12'h100, 12'h100, 1, 0, 0);
        addVec(1, 0, 0,     1, STOP, 0,     12'h100, 1, 0, 0);
        addVec(1, 0, 0,     1, STOP, 0,     12'h100, 1, 0, 0);
        addVec(1, 0, 0,     1, STOP, 0,     12'h100, 1, 0, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h101, 1, 0, 0);
        addVec(1, 1, 12'h300, 0, 0,  0,     12'h102, 1, 0, 0);
        addVec(1, 0, 0,     0, STOP, 0,     12'h000, 0, 1, 0);
        addVec(1, 1, 12'h020, 0, 0,  0,     12'h020, 1, 0, 0);
        // Three-iteration loop body at 1..2, then ENDL on an empty stack.
        addVec(1, 0, 0,     0, JUMP, 0,     12'h000, 1, 0, 0);
        addVec(1, 0, 0,     0, LOOP, 3,     12'h001, 1, 0, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h002, 1, 0, 0);
        addVec(1, 0, 0,     0, ENDL, 0,     12'h001, 1, 0, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h002, 1, 0, 0);
        addVec(1, 0, 0,     0, ENDL, 0,     12'h001, 1, 0, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h002, 1, 0, 0);
        addVec(1, 0, 0,     0, ENDL, 0,     12'h003, 1, 0, 0);
        addVec(1, 0, 0,     0, ENDL, 0,     12'h004, 1, 0, 1);
        addVec(1, 0, 0,     0, 0,    0,     12'h005, 1, 0, 1);
        addVec(1, 0, 0,     0, STOP, 0,     12'h000, 0, 1, 1);
        addVec(1, 1, 12'h0FF, 0, 0,  0,     12'h0FF, 1, 0, 0);
        // Overflow the stack with one push too many, then reset mid-loop.
        addVec(1, 0, 0,     0, LOOP, 2,     12'h100, 1, 0, 0);
        addVec(1, 0, 0,     0, LOOP, 2,     12'h101, 1, 0, 0);
        addVec(1, 0, 0,     0, LOOP, 2,     12'h102, 1, 0, 0);
        addVec(1, 0, 0,     0, LOOP, 2,     12'h103, 1, 0, 0);
        addVec(1, 0, 0,     0, LOOP, 2,     12'h104, 1, 0, 1);
        addVec(1, 0, 0,     0, ENDL, 0,     12'h103, 1, 0, 1);
        addVec(1, 0, 0,     1, ENDL, 0,     12'h103, 1, 0, 1);
        addVec(0, 1, 12'h222, 1, ENDL, 0,   12'h000, 0, 0, 0);
        addVec(1, 0, 0,     0, 0,    0,     12'h000, 0, 0, 0);
        // Wrap from all-ones, and ENDL right after the reset finds the stack empty.
        addVec(1, 1, 12'hFFE, 0, 0,  0,     12'hFFE, 1, 0, 0);
        addVec(1, 0, 0,     0, 3,    0,     12'hFFF, 1, 0, 0);
        addVec(1, 0, 0,     0, 5,    0,     12'h000, 1, 0, 0);
        addVec(1, 0, 0,     0, ENDL, 0,     12'h001, 1, 0, 1);
        addVec(1, 0, 0,     0, STOP, 12'h0AB, 12'h000, 0, 1, 1);
        addVec(1, 0, 0,     0, 0,    0,     12'h000, 0, 0, 1);
        // Zero count behaves as a single pass: one ENDL pops, the next one faults.
        addVec(1, 1, 12'h040, 0, 0,  0,     12'h040, 1, 0, 0);
        addVec(1, 0, 0,     0, LOOP, 12'h100, 12'h041, 1, 0, 0);
        addVec(1, 0, 0,     0, ENDL, 0,     12'h042, 1, 0, 0);
        addVec(1, 0, 0,     0, ENDL, 0,     12'h043, 1, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstn, vecs[i].valid, int'(vecs[i].startAddr), vecs[i].stall,
                          int'(vecs[i].instr), int'(vecs[i].operand));
            checkOutput($sformatf("vec%0d", i), int'(vecs[i].expPc), vecs[i].expBusy,
                        vecs[i].expDone, vecs[i].expErr);
        end

        $display("[TB] directed vectors applied, starting random phase");
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rnd_reset", mPc, mBusy, mDone, mErr);
        for (int n = 0; n < 3000; n++) begin
            int ins;
            int op;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       ins = STOP;
                1:       ins = JUMP;
                2, 3:    ins = LOOP;
                4, 5:    ins = ENDL;
                default: ins = $urandom_range(0, 15);
            endcase
            op = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 4095);
            applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
                          $urandom_range(0, 4095), ($urandom_range(0, 4) == 0), ins, op);
            checkOutput($sformatf("rnd%0d", n), mPc, mBusy, mDone, mErr);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
